// File: rtl/rld_multi.sv
// rld_multi: N independent run-length decoders, each a small code FIFO feeding a pixel expander.
// Optional macro RLD_ZERO_RUN_MAX_EN: a zero run expands to 2^RUN_W pixels instead of being discarded.
module rld_multi #(
   parameter int  NUM_CH     = 3,
   parameter int  PIX_W      = 8,
   parameter int  RUN_W      = 8,
   parameter int  FIFO_DEPTH = 4,
   localparam int CODE_W     = RUN_W + PIX_W,
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [NUM_CH*CODE_W-1:0] in_code,
   input  logic [NUM_CH-1:0]        in_last,
   input  logic [NUM_CH-1:0]        flush,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*PIX_W-1:0]  out_pix,
   output logic [NUM_CH-1:0]        out_last,
   output logic [NUM_CH-1:0]        done,
   output logic [NUM_CH*LVL_W-1:0]  level
);
   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [RUN_W:0]   CNT_ONE  = (RUN_W+1)'(1);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic {ST_IDLE, ST_EMIT} state_t;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CODE_W:0]    r_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]   r_wptr;
      logic [PTR_W-1:0]   r_rptr;
      logic [LVL_W-1:0]   r_level;
      state_t             r_state;
      state_t             w_stateNext;
      logic [RUN_W:0]     r_cnt;
      logic [PIX_W-1:0]   r_pix;
      logic               r_last;
      logic               r_done;

      logic               w_full;
      logic               w_empty;
      logic               w_push;
      logic               w_pop;
      logic               w_load;
      logic               w_fire;
      logic               w_final;
      logic [CODE_W:0]    w_head;
      logic [RUN_W-1:0]   w_headRun;
      logic [RUN_W:0]     w_headCnt;
      logic               w_headZero;

      // FIFO entry layout is {last, run, pix}
      assign w_head    = r_mem[r_rptr];
      assign w_headRun = w_head[CODE_W-1:PIX_W];

`ifdef RLD_ZERO_RUN_MAX_EN
      assign w_headCnt  = (w_headRun == '0) ? {1'b1, {RUN_W{1'b0}}} : {1'b0, w_headRun};
      assign w_headZero = 1'b0;
`else
      assign w_headCnt  = {1'b0, w_headRun};
      assign w_headZero = (w_headRun == '0);
`endif

      assign w_full   = (r_level == LVL_FULL);
      assign w_empty  = (r_level == '0);
      assign w_push   = in_valid[c] & in_ready[c];
      assign w_fire   = (r_state == ST_EMIT) & out_ready[c];
      assign w_final  = w_fire & (r_cnt == CNT_ONE);

      assign in_ready[c]                  = rst & ~w_full & ~flush[c];
      assign out_valid[c]                 = (r_state == ST_EMIT);
      assign out_pix[c*PIX_W +: PIX_W]    = r_pix;
      assign out_last[c]                  = (r_state == ST_EMIT) & (r_cnt == CNT_ONE) & r_last;
      assign done[c]                      = r_done;
      assign level[c*LVL_W +: LVL_W]      = r_level;

      // Chaining only loads a non-empty run; a discardable head is left for IDLE so its done pulse
      // cannot collide with the done of the run that just finished.
      always_comb begin
         w_stateNext = r_state;
         w_pop       = 1'b0;
         w_load      = 1'b0;
         if (!flush[c]) begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_empty) begin
                     w_pop = 1'b1;
                     if (!w_headZero) begin
                        w_load      = 1'b1;
                        w_stateNext = ST_EMIT;
                     end
                  end
               end
               ST_EMIT: begin
                  if (w_final) begin
                     if (!w_empty && !w_headZero) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                     end else begin
                        w_stateNext = ST_IDLE;
                     end
                  end
               end
               default: w_stateNext = ST_IDLE;
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_state <= ST_IDLE;
         end else if (flush[c]) begin
            r_state <= ST_IDLE;
         end else begin
            r_state <= w_stateNext;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
         end else if (flush[c]) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
         end else begin
            if (w_push) begin
               r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
               r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + LVL_ONE;
               2'b01:   r_level <= r_level - LVL_ONE;
               default: r_level <= r_level;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (w_push) begin
            r_mem[r_wptr] <= {in_last[c], in_code[c*CODE_W +: CODE_W]};
         end
      end

      // A frame-end pulse comes either from the last pixel handshake or from discarding a last zero-run code
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_cnt  <= '0;
            r_pix  <= '0;
            r_last <= 1'b0;
            r_done <= 1'b0;
         end else if (flush[c]) begin
            r_cnt  <= '0;
            r_last <= 1'b0;
            r_done <= 1'b0;
         end else begin
            r_done <= (w_final & r_last) | (w_pop & w_headZero & w_head[CODE_W]);
            if (w_load) begin
               r_cnt  <= w_headCnt;
               r_pix  <= w_head[PIX_W-1:0];
               r_last <= w_head[CODE_W];
            end else if (w_fire) begin
               r_cnt  <= r_cnt - CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_rld_multi.sv
// tb_rld_multi: directed and randomized checks of rld_multi against a pixel-list reference model.
// Each accepted code is expanded into its expected pixel list; the monitor logs every output handshake.
module tb_rld_multi;
   localparam int NUM_CH     = 3;
   localparam int PIX_W      = 8;
   localparam int RUN_W      = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int CODE_W     = RUN_W + PIX_W;
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
   localparam int MAXP       = 4096;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic [NUM_CH-1:0]        inValid;
   logic [NUM_CH-1:0]        inReady;
   logic [NUM_CH*CODE_W-1:0] inCode;
   logic [NUM_CH-1:0]        inLast;
   logic [NUM_CH-1:0]        flush;
   logic [NUM_CH-1:0]        outValid;
   logic [NUM_CH-1:0]        outReady;
   logic [NUM_CH*PIX_W-1:0]  outPix;
   logic [NUM_CH-1:0]        outLast;
   logic [NUM_CH-1:0]        done;
   logic [NUM_CH*LVL_W-1:0]  level;

   int total = 0;
   int bad   = 0;

   logic [PIX_W:0] expPix [NUM_CH][MAXP];
   logic [PIX_W:0] obsPix [NUM_CH][MAXP];
   int             expN    [NUM_CH];
   int             obsN    [NUM_CH];
   int             expDone [NUM_CH];
   int             obsDone [NUM_CH];

   rld_multi #(
      .NUM_CH(NUM_CH), .PIX_W(PIX_W), .RUN_W(RUN_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(inValid), .in_ready(inReady), .in_code(inCode), .in_last(inLast),
      .flush(flush),
      .out_valid(outValid), .out_ready(outReady), .out_pix(outPix), .out_last(outLast),
      .done(done), .level(level)
   );

   always #5 clk = ~clk;

   // Output handshakes and done pulses are logged mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (outValid[c] && outReady[c]) begin
               if (obsN[c] < MAXP) obsPix[c][obsN[c]] = {outLast[c], outPix[c*PIX_W +: PIX_W]};
               obsN[c]++;
            end
            if (done[c]) obsDone[c]++;
         end
      end
   end

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LVL_W-1:0] lvl(int c);
      return level[c*LVL_W +: LVL_W];
   endfunction

   function automatic int effRun(int run);
`ifdef RLD_ZERO_RUN_MAX_EN
      return (run == 0) ? (1 << RUN_W) : run;
`else
      return run;
`endif
   endfunction

   task automatic clearScore();
      for (int c = 0; c < NUM_CH; c++) begin
         expN[c] = 0; obsN[c] = 0; expDone[c] = 0; obsDone[c] = 0;
      end
   endtask

   task automatic modelPush(int c, int run, logic [PIX_W-1:0] pix, logic last);
      int n;
      n = effRun(run);
      for (int k = 0; k < n; k++) begin
         if (expN[c] < MAXP) expPix[c][expN[c]] = {(last && (k == n - 1)), pix};
         expN[c]++;
      end
      if (last) expDone[c]++;
   endtask

   task automatic setCode(int c, int run, logic [PIX_W-1:0] pix, logic last);
      inCode[c*CODE_W +: CODE_W] = {RUN_W'(run), pix};
      inLast[c] = last;
   endtask

   task automatic pushOne(int c, int run, logic [PIX_W-1:0] pix, logic last);
      setCode(c, run, pix, last);
      inValid[c] = 1'b1;
      tick();
      inValid[c] = 1'b0;
      modelPush(c, run, pix, last);
   endtask

   function automatic int firstDiff(int c);
      int n;
      n = (expN[c] < obsN[c]) ? expN[c] : obsN[c];
      if (n > MAXP) n = MAXP;
      for (int i = 0; i < n; i++) begin
         if (obsPix[c][i] !== expPix[c][i]) return i;
      end
      return -1;
   endfunction

   task automatic test_reset();
      inValid = '0; inCode = '0; inLast = '0; flush = '0; outReady = '0;
      rst = 1'b0;
      clearScore();
      #12;
      total++; if (outValid !== '0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", outValid); end
      total++; if (outPix !== '0) begin bad++; $display("[TB] FAIL reset_out_pix got=%h want=0", outPix); end
      total++; if (outLast !== '0 || done !== '0) begin bad++; $display("[TB] FAIL reset_last_done got=%b/%b want=0/0", outLast, done); end
      total++; if (level !== '0) begin bad++; $display("[TB] FAIL reset_level got=%h want=0", level); end
      total++; if (inReady !== '0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", inReady); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (inReady !== '1) begin bad++; $display("[TB] FAIL release_in_ready got=%b want=111", inReady); end
      tick();
   endtask

   task automatic test_single_code();
      int d;
      clearScore();
      outReady = 3'b001;
      pushOne(0, 3, 8'h5A, 1'b1);
      total++; if (outValid[0] !== 1'b0 || lvl(0) !== LVL_W'(1)) begin bad++; $display("[TB] FAIL single_after_push valid=%b level=%0d want 0/1", outValid[0], lvl(0)); end
      tick();
      total++; if (outValid[0] !== 1'b1 || outPix[7:0] !== 8'h5A || outLast[0] !== 1'b0) begin bad++; $display("[TB] FAIL single_first_pix valid=%b pix=%h last=%b want 1/5a/0", outValid[0], outPix[7:0], outLast[0]); end
      tick(); tick();
      total++; if (outValid[0] !== 1'b1 || outPix[7:0] !== 8'h5A || outLast[0] !== 1'b1) begin bad++; $display("[TB] FAIL single_third_pix valid=%b pix=%h last=%b want 1/5a/1", outValid[0], outPix[7:0], outLast[0]); end
      tick();
      total++; if (outValid[0] !== 1'b0 || done[0] !== 1'b1) begin bad++; $display("[TB] FAIL single_done valid=%b done=%b want 0/1", outValid[0], done[0]); end
      tick();
      total++; if (done[0] !== 1'b0) begin bad++; $display("[TB] FAIL single_done_width done=%b want 0", done[0]); end
      d = firstDiff(0);
      total++; if (obsN[0] !== expN[0] || d !== -1) begin bad++; $display("[TB] FAIL single_stream count=%0d want=%0d diffAt=%0d", obsN[0], expN[0], d); end
      total++; if (obsDone[0] !== 1) begin bad++; $display("[TB] FAIL single_done_count got=%0d want=1", obsDone[0]); end
   endtask

   task automatic test_back_to_back();
      int bubbles;
      int d;
      clearScore();
      outReady = 3'b000;
      for (int i = 0; i < 5; i++) pushOne(1, 2, 8'($urandom), (i == 4));
      total++; if (lvl(1) !== LVL_W'(4) || inReady[1] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_full level=%0d ready=%b want 4/0", lvl(1), inReady[1]); end
      outReady[1] = 1'b1;
      bubbles = 0;
      for (int i = 0; i < 10; i++) begin
         if (outValid[1] !== 1'b1) bubbles++;
         tick();
      end
      total++; if (bubbles !== 0) begin bad++; $display("[TB] FAIL b2b_bubbles got=%0d want=0", bubbles); end
      total++; if (outValid[1] !== 1'b0 || done[1] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_end valid=%b done=%b want 0/1", outValid[1], done[1]); end
      tick();
      d = firstDiff(1);
      total++; if (obsN[1] !== expN[1] || d !== -1) begin bad++; $display("[TB] FAIL b2b_stream count=%0d want=%0d diffAt=%0d", obsN[1], expN[1], d); end
      outReady = 3'b000;
   endtask

   task automatic test_stall();
      logic           prevStall;
      logic [PIX_W:0] prevVal;
      int             unstable;
      int             d;
      clearScore();
      outReady = 3'b000;
      pushOne(2, 5, 8'hC3, 1'b0);
      tick();
      prevStall = 1'b0; prevVal = '0; unstable = 0;
      for (int i = 0; i < 20; i++) begin
         outReady[2] = (i % 2 == 1);
         @(negedge clk);
         if (prevStall && ({outLast[2], outPix[23:16]} !== prevVal || outValid[2] !== 1'b1)) unstable++;
         prevStall = outValid[2] && !outReady[2];
         prevVal   = {outLast[2], outPix[23:16]};
         tick();
      end
      total++; if (unstable !== 0) begin bad++; $display("[TB] FAIL stall_stable changes=%0d want=0", unstable); end
      d = firstDiff(2);
      total++; if (obsN[2] !== 5 || d !== -1) begin bad++; $display("[TB] FAIL stall_stream count=%0d want=5 diffAt=%0d", obsN[2], d); end
      total++; if (outValid[2] !== 1'b0 || obsDone[2] !== 0) begin bad++; $display("[TB] FAIL stall_end valid=%b doneCount=%0d want 0/0", outValid[2], obsDone[2]); end
      outReady = 3'b000;
   endtask

   task automatic test_zero_run();
      int d;
      clearScore();
      outReady = 3'b001;
      pushOne(0, 0, 8'h11, 1'b1);
`ifdef RLD_ZERO_RUN_MAX_EN
      for (int i = 0; i < 400 && obsDone[0] == 0; i++) tick();
      d = firstDiff(0);
      total++; if (obsN[0] !== 256 || d !== -1) begin bad++; $display("[TB] FAIL zero_run_max count=%0d want=256 diffAt=%0d", obsN[0], d); end
      total++; if (obsDone[0] !== 1 || outValid[0] !== 1'b0) begin bad++; $display("[TB] FAIL zero_run_done count=%0d valid=%b want 1/0", obsDone[0], outValid[0]); end
`else
      begin
         int sawValid;
         sawValid = 0;
         for (int i = 0; i < 6; i++) begin
            if (outValid[0]) sawValid++;
            tick();
         end
         d = firstDiff(0);
         total++; if (sawValid !== 0 || obsN[0] !== 0) begin bad++; $display("[TB] FAIL zero_run_discard validCycles=%0d pixels=%0d want 0/0", sawValid, obsN[0]); end
         total++; if (obsDone[0] !== 1 || lvl(0) !== '0) begin bad++; $display("[TB] FAIL zero_run_done count=%0d level=%0d want 1/0", obsDone[0], lvl(0)); end
      end
`endif
      outReady = 3'b000;
   endtask

   task automatic test_flush();
      logic [PIX_W-1:0] p0;
      logic [PIX_W-1:0] p1;
      int               gaps;
      int               d0;
      int               d1;
      clearScore();
      p0 = 8'($urandom); p1 = 8'($urandom);
      outReady = 3'b011;
      setCode(0, 8, p0, 1'b1);
      setCode(1, 10, p1, 1'b1);
      inValid = 3'b011;
      tick();
      inValid = 3'b000;
      for (int k = 0; k < 4; k++) begin
         expPix[0][expN[0]] = {1'b0, p0};
         expN[0]++;
      end
      modelPush(1, 10, p1, 1'b1);
      tick();
      repeat (4) tick();
      outReady[0] = 1'b0;
      flush[0] = 1'b1;
      tick();
      flush[0] = 1'b0;
      total++; if (outValid[0] !== 1'b0 || lvl(0) !== '0 || outLast[0] !== 1'b0) begin bad++; $display("[TB] FAIL flush_clear valid=%b level=%0d last=%b want 0/0/0", outValid[0], lvl(0), outLast[0]); end
      outReady[0] = 1'b1;
      gaps = 0;
      for (int i = 0; i < 5; i++) begin
         if (outValid[1] !== 1'b1) gaps++;
         tick();
      end
      total++; if (gaps !== 0 || outValid[1] !== 1'b0) begin bad++; $display("[TB] FAIL flush_other_channel gaps=%0d validAfter=%b want 0/0", gaps, outValid[1]); end
      tick(); tick();
      d0 = firstDiff(0);
      d1 = firstDiff(1);
      total++; if (obsN[0] !== expN[0] || d0 !== -1 || obsDone[0] !== 0) begin bad++; $display("[TB] FAIL flush_ch0_stream count=%0d want=%0d diffAt=%0d done=%0d", obsN[0], expN[0], d0, obsDone[0]); end
      total++; if (obsN[1] !== expN[1] || d1 !== -1 || obsDone[1] !== 1) begin bad++; $display("[TB] FAIL flush_ch1_stream count=%0d want=%0d diffAt=%0d done=%0d", obsN[1], expN[1], d1, obsDone[1]); end
      outReady = 3'b000;
   endtask

   task automatic test_reset_mid();
      logic [PIX_W-1:0] p;
      int               d;
      clearScore();
      outReady = 3'b111;
      for (int c = 0; c < NUM_CH; c++) setCode(c, 6, 8'($urandom), 1'b1);
      inValid = 3'b111;
      tick();
      inValid = 3'b000;
      tick(); tick();
      #2 rst = 1'b0;
      #1;
      total++; if (outValid !== '0 || outPix !== '0 || outLast !== '0 || done !== '0) begin bad++; $display("[TB] FAIL midreset_outputs valid=%b pix=%h last=%b done=%b want all 0", outValid, outPix, outLast, done); end
      total++; if (level !== '0 || inReady !== '0) begin bad++; $display("[TB] FAIL midreset_level_ready level=%h ready=%b want 0/0", level, inReady); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (inReady !== '1) begin bad++; $display("[TB] FAIL midreset_release_ready got=%b want=111", inReady); end
      tick(); tick();
      total++; if (obsDone[0] + obsDone[1] + obsDone[2] !== 0) begin bad++; $display("[TB] FAIL midreset_no_done got=%0d want=0", obsDone[0] + obsDone[1] + obsDone[2]); end
      clearScore();
      p = 8'($urandom);
      pushOne(0, 1, p, 1'b1);
      repeat (4) tick();
      d = firstDiff(0);
      total++; if (obsN[0] !== 1 || d !== -1 || obsDone[0] !== 1) begin bad++; $display("[TB] FAIL midreset_new_code count=%0d diffAt=%0d done=%0d want 1/-1/1", obsN[0], d, obsDone[0]); end
      outReady = 3'b000;
   endtask

   task automatic test_random();
      logic [NUM_CH-1:0] acc;
      int                runs [NUM_CH];
      logic [PIX_W-1:0]  pixs [NUM_CH];
      logic              lasts [NUM_CH];
      int                drained;
      int                d;
      clearScore();
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            outReady[c] = ($urandom_range(0, 3) != 0);
`ifdef RLD_ZERO_RUN_MAX_EN
            runs[c]  = $urandom_range(1, 4);
`else
            runs[c]  = $urandom_range(0, 4);
`endif
            pixs[c]  = 8'($urandom);
            lasts[c] = ($urandom_range(0, 3) == 0);
            setCode(c, runs[c], pixs[c], lasts[c]);
            inValid[c] = ($urandom_range(0, 1) == 1);
         end
         #1;
         acc = inValid & inReady;
         @(posedge clk);
         for (int c = 0; c < NUM_CH; c++) if (acc[c]) modelPush(c, runs[c], pixs[c], lasts[c]);
         #1;
      end
      inValid = '0;
      outReady = '1;
      drained = 0;
      for (int i = 0; i < 2000 && drained == 0; i++) begin
         if (level == '0 && outValid == '0) drained = 1;
         else tick();
      end
      tick(); tick();
      total++; if (drained !== 1) begin bad++; $display("[TB] FAIL random_drain timeout level=%h valid=%b", level, outValid); end
      for (int c = 0; c < NUM_CH; c++) begin
         d = firstDiff(c);
         total++; if (obsN[c] !== expN[c] || d !== -1) begin bad++; $display("[TB] FAIL random_stream ch=%0d count=%0d want=%0d diffAt=%0d", c, obsN[c], expN[c], d); end
         total++; if (obsDone[c] !== expDone[c]) begin bad++; $display("[TB] FAIL random_done ch=%0d got=%0d want=%0d", c, obsDone[c], expDone[c]); end
      end
      outReady = '0;
   endtask

   initial begin
      $display("[TB] rld_multi bench start");
      test_reset();
      test_single_code();
      test_back_to_back();
      test_stall();
      test_zero_run();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
